tipi_rpi_link: RTL
==================

# tipi_rpi_link

Master-side serial engine for the TIPI latch link, standing in for the Raspberry Pi. It drives `r_clk`/`r_rt`/`r_le`/`r_dout`/`r_dc` into the TIPI PEB card model and samples `r_din`. It turns single-byte host commands into complete write (Pi→TI, into RD/RC) or read (TI→Pi, from TD/TC) transactions. It sits directly across the link from the PEB card and is fed by the soft CPU or a test harness through a valid/ready command port.

## Interface
- `HALF_PERIOD`, default 12: `clk` cycles per `r_clk` phase. Legal range is ≥10; the value is not checked in RTL.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE. A command is accepted when `cmd_valid && cmd_ready`.
- `cmd_read` in 1: 1 = read from the TI (TD/TC); 0 = write to the TI (RD/RC).
- `cmd_dc` in 1: 1 = data latch (TD/RD); 0 = control latch (TC/RC).
- `cmd_wdata` in [0:7]: write byte. Bit 0 is sent first.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out [0:7]: read byte. Bit 0 is received first. Holds its value until the next read completes.
- `rsp_err` out 1: qualified by `rsp_valid`; the transfer was aborted because the link was held in reset.
- `link_up` out 1: synchronised `!r_reset`.
- `r_clk`, `r_rt`, `r_le`, `r_dout`, `r_dc` out 1: link drive. All are registered.
- `r_din` in 1: link return data. Asynchronous; passes through a 2-flop synchroniser.
- `r_reset` in 1: link held in reset. Asynchronous; passes through a 2-flop synchroniser.

## Operation
- Reset values: `r_clk`, `r_rt`, `r_le`, `r_dout`, `r_dc` = 0; `rsp_valid` = 0, `rsp_rdata` = 00, `rsp_err` = 0, `link_up` = 0; state IDLE, so `cmd_ready` = 1. Both synchronisers clear to 0.
- States:
  - IDLE: on accept, latch `cmd_*`, set bit index 0 and go to LOW.
  - LOW: `r_clk`=0 for `HALF_PERIOD` cycles, then go to HIGH.
  - HIGH: `r_clk`=1 for `HALF_PERIOD` cycles. Then go to LOW if index < 8 (incrementing the index), else go to DONE.
  - DONE: one cycle; pulse `rsp_valid`, then go to IDLE.
- One bit period is one LOW+HIGH pair. Each transaction is exactly 9 periods, indices 0..8.
- `r_rt`/`r_le`/`r_dout`/`r_dc` change only on the first cycle of LOW. They are then stable for the whole period.
- Write transaction (`cmd_read`=0), `r_rt`=0 throughout:
  - Periods 0..7: `r_le`=0, `r_dout`=`cmd_wdata[index]`.
  - Period 8: `r_le`=1, `r_dout`=0, `r_dc`=`cmd_dc`.
  - The PEB captures the byte into RD (`dc`=1) or RC (`dc`=0).
- Read transaction (`cmd_read`=1), `r_rt`=1 throughout:
  - Period 0: `r_le`=1, `r_dc`=`cmd_dc`. This loads TD/TC into the PEB shifter.
  - Periods 1..8: `r_le`=0, `r_dout`=0.
  - On the last cycle of HIGH in period k (1..8), capture synchronised `r_din` into `rdata[k-1]`.
  - `rsp_rdata` is updated in DONE.
- In DONE, `r_le` and `r_rt` return to 0. `r_dc` and `r_dout` return to 0.
- Link reset:
  - If synchronised `r_reset`=1 when a command is accepted, the command goes straight to DONE with `rsp_err`=1 and no `r_clk` activity.
  - If `r_reset` rises mid-transaction, the current phase ends, `r_clk` is forced 0 and the FSM goes to DONE with `rsp_err`=1.
  - In either error case `rsp_rdata` is unchanged.
- `cmd_valid` is ignored outside IDLE. There is no queueing.
- Asynchronous reset mid-transaction returns all registers to their reset values immediately. No `rsp_valid` is issued.

## Timing
- Accept at cycle t. LOW of period 0 starts at t+1.
- `rsp_valid` occurs at t+1+18·`HALF_PERIOD`. With the default, that is t+217.
- `cmd_ready` falls at t+1 and returns at the cycle after `rsp_valid`. The minimum spacing between accepts is 18·`HALF_PERIOD`+2.
- `r_clk` has a 50% duty cycle. Every rising edge is preceded by ≥10 low cycles; the PEB needs ≥3.
- The read sample point is `HALF_PERIOD`-1 cycles after the rise, including the 2-cycle synchroniser. This covers the PEB's ~6-cycle edge-detect-plus-shift latency.
- Error path: the accept-to-DONE latency when already in reset is 2 cycles. Mid-op, it is at most `HALF_PERIOD`+2 after `r_reset` rises.

## Test plan
- Write 0x5A, `dc`=1, connected to the PEB card model with `rpi_enable`=1: observe `r_dout` sequence 0,1,0,1,1,0,1,0 then a latch period → PEB RD reads 0x5A; `rsp_err`=0; `rsp_valid` 217 cycles after accept.
- Read, `dc`=1, after PEB reset → `rsp_rdata`=0xAB (TD default). TI then writes TC=0x3C; read with `dc`=0 → 0x3C.
- Write, `dc`=0, data 0x81 → PEB RC=0x81 and RD unchanged; the immediate back-to-back read of TD → 0xAB; `cmd_ready` low throughout both.
- `rpi_enable`=0 (`r_reset`=1): a command → `rsp_valid`+`rsp_err` 2 cycles later, `r_clk` never toggles, `link_up`=0.
- Clear `rpi_enable` during period 4 of a read → `r_clk` ends low, `rsp_err`=1, and `rsp_rdata` keeps its previous value.
- Assert `reset_n` low mid-write → all link outputs 0 at once, no `rsp_valid`, `cmd_ready`=1 after release; a fresh write of 0xC3 completes correctly.

Source files
------------

// File: rtl/tipi_rpi_link_if.sv
// Command/response port of the TIPI link master engine.
// The host drives commands through the master modport, and the engine serves them through the slave modport.
interface tipi_rpi_link_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_read;
  logic       cmd_dc;
  logic [0:7] cmd_wdata;
  logic       rsp_valid;
  logic [0:7] rsp_rdata;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_read, cmd_dc, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_dc, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/tipi_rpi_link.sv
// Pi-side serial master for the TIPI latch link.
// Each command becomes a 9-period write (into RD/RC) or read (from TD/TC) on r_clk.
module tipi_rpi_link #(
  parameter int HALF_PERIOD = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  tipi_rpi_link_if.slave  host,
  output logic            link_up,
  output logic            r_clk,
  output logic            r_rt,
  output logic            r_le,
  output logic            r_dout,
  output logic            r_dc,
  input  logic            r_din,
  input  logic            r_reset
);

  localparam int CNT_W = $clog2(HALF_PERIOD);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] ph_cnt;
  logic [3:0]       bit_idx;
  logic             op_read;
  logic             op_dc;
  logic             abort;
  logic [0:7]       op_wdata;
  logic [0:6]       rdata_sh;
  logic             din_p0, din_p1;
  logic             lrst_p0, lrst_p1;
  logic             ph_last;

  assign ph_last = (ph_cnt == CNT_W'(HALF_PERIOD - 1));

  // Link pin pattern {rt, le, dout, dc} for bit period idx.
  function automatic logic [3:0] link_bits(input logic rd, input logic dc,
                                           input logic [0:7] wd, input logic [3:0] idx);
    logic [3:0] b;
    if (rd)
      b = {1'b1, idx == 4'd0, 1'b0, dc};
    else if (idx == 4'd8)
      b = {1'b0, 1'b1, 1'b0, dc};
    else
      b = {1'b0, 1'b0, wd[idx[2:0]], dc};
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_p0  <= 1'b0;
      din_p1  <= 1'b0;
      lrst_p0 <= 1'b0;
      lrst_p1 <= 1'b0;
      link_up <= 1'b0;
    end else begin
      din_p0  <= r_din;
      din_p1  <= din_p0;
      lrst_p0 <= r_reset;
      lrst_p1 <= lrst_p0;
      link_up <= ~lrst_p1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      ph_cnt         <= '0;
      bit_idx        <= 4'd0;
      op_read        <= 1'b0;
      op_dc          <= 1'b0;
      op_wdata       <= 8'h00;
      abort          <= 1'b0;
      rdata_sh       <= 7'h00;
      r_clk          <= 1'b0;
      r_rt           <= 1'b0;
      r_le           <= 1'b0;
      r_dout         <= 1'b0;
      r_dc           <= 1'b0;
      host.cmd_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= 8'h00;
      host.rsp_err   <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (host.cmd_valid && host.cmd_ready) begin
            op_read        <= host.cmd_read;
            op_dc          <= host.cmd_dc;
            op_wdata       <= host.cmd_wdata;
            bit_idx        <= 4'd0;
            ph_cnt         <= '0;
            abort          <= lrst_p1;
            host.cmd_ready <= 1'b0;
            state          <= LOW;
            // A link already in reset gets no pin activity at all.
            if (!lrst_p1)
              {r_rt, r_le, r_dout, r_dc} <= link_bits(host.cmd_read, host.cmd_dc,
                                                      host.cmd_wdata, 4'd0);
          end
        end
        LOW: begin
          if (abort) begin
            state                      <= DONE;
            host.rsp_valid             <= 1'b1;
            host.rsp_err               <= 1'b1;
            {r_rt, r_le, r_dout, r_dc} <= 4'b0000;
          end else if (ph_last) begin
            ph_cnt <= '0;
            if (lrst_p1) begin
              state                      <= DONE;
              host.rsp_valid             <= 1'b1;
              host.rsp_err               <= 1'b1;
              {r_rt, r_le, r_dout, r_dc} <= 4'b0000;
            end else begin
              state <= HIGH;
              r_clk <= 1'b1;
            end
          end else begin
            ph_cnt <= ph_cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (ph_last) begin
            ph_cnt <= '0;
            r_clk  <= 1'b0;
            // Sample point: HALF_PERIOD-1 cycles after the rise, synchroniser included.
            if (op_read && bit_idx != 4'd0 && bit_idx != 4'd8)
              rdata_sh[3'(bit_idx - 4'd1)] <= din_p1;
            if (lrst_p1) begin
              state                      <= DONE;
              host.rsp_valid             <= 1'b1;
              host.rsp_err               <= 1'b1;
              {r_rt, r_le, r_dout, r_dc} <= 4'b0000;
            end else if (bit_idx < 4'd8) begin
              bit_idx <= bit_idx + 4'd1;
              state   <= LOW;
              {r_rt, r_le, r_dout, r_dc} <= link_bits(op_read, op_dc, op_wdata,
                                                      bit_idx + 4'd1);
            end else begin
              state                      <= DONE;
              host.rsp_valid             <= 1'b1;
              host.rsp_err               <= 1'b0;
              {r_rt, r_le, r_dout, r_dc} <= 4'b0000;
              if (op_read)
                host.rsp_rdata <= {rdata_sh, din_p1};
            end
          end else begin
            ph_cnt <= ph_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state          <= IDLE;
          abort          <= 1'b0;
          host.cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
